// File: rtl/lz_restore_if.sv
`default_nettype none
// ============================================================================
// Module   : lz_restore_if
// Brief    : Operand/result bundle for the lz_restore denormalizer.
// Revision : 1.0 - initial release
// ============================================================================
interface lz_restore_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             start;
    logic [WIDTH-1:0] mantissa;
    logic [CNT_W-1:0] zero_count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             count_err;

    modport master (
        output start, mantissa, zero_count,
        input  busy, done, result, count_err
    );

    modport slave (
        input  start, mantissa, zero_count,
        output busy, done, result, count_err
    );
endinterface
`default_nettype wire

// File: rtl/lz_restore.sv
`default_nettype none
// ============================================================================
// Module   : lz_restore
// Brief    : Multi-cycle inverse of count-leading-zeros (result = mantissa >> zero_count).
// Revision : 1.0 - initial release
// ============================================================================
module lz_restore #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic       clk,
    input  wire logic       rst,
    lz_restore_if.slave     bus
);
    localparam int                    c_STEP_W    = $clog2(CNT_W);
    localparam logic [c_STEP_W-1:0]   c_LAST_STEP = c_STEP_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0]      c_WIDTH_CNT = CNT_W'(WIDTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [c_STEP_W-1:0] r_step;
    logic [WIDTH-1:0]    r_work;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_result;
    logic                r_err;

    logic [WIDTH-1:0]    w_shift_opt [CNT_W];
    logic [WIDTH-1:0]    w_next_work;
    logic                w_accept;
    logic                w_oversize;

    // Each step only ever shifts by its own fixed power of two, so every
    // candidate is plain wiring and the per-cycle cost is one small mux.
    generate
        for (genvar k = 0; k < CNT_W; k++) begin : g_step
            if ((2 ** k) >= WIDTH) begin : g_flush
                assign w_shift_opt[k] = '0;
            end else begin : g_shift
                assign w_shift_opt[k] = r_work >> (2 ** k);
            end
        end
    endgenerate

    always_comb begin
        w_next_work = r_work;
        if (r_cnt[r_step]) begin
            w_next_work = w_shift_opt[r_step];
        end
    end

    assign w_accept   = bus.start && !r_busy;
    assign w_oversize = (bus.zero_count >= c_WIDTH_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_step   <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_accept) begin
                        r_work  <= w_oversize ? '0 : bus.mantissa;
                        r_cnt   <= bus.zero_count;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_SHIFT;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_SHIFT: begin
                    r_work <= w_next_work;
                    // The final step's shifted value goes straight to the
                    // output so completion lands CNT_W edges after accept.
                    if (r_step == c_LAST_STEP) begin
                        r_result <= w_next_work;
                        r_err    <= (r_cnt > c_WIDTH_CNT);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.count_err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_lz_restore.sv
`default_nettype none
// ============================================================================
// Module   : tb_lz_restore
// Brief    : Directed and randomized self-checking bench for lz_restore.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lz_restore;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [5:0]  zc;
    } exp_t;

    exp_t sb[$];

    lz_restore_if #(.WIDTH(32), .CNT_W(6)) bus ();

    lz_restore #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lzc(input logic [31:0] v);
        int n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] m, input logic [5:0] z);
        exp_t e;
        bus.start      = 1'b1;
        bus.mantissa   = m;
        bus.zero_count = z;
        e.res = (z >= 6'd32) ? 32'h0 : (m >> z);
        e.err = (z > 6'd32);
        e.zc  = z;
        sb.push_back(e);
        tick();
        bus.start      = 1'b0;
        // Scramble operands after the accepting edge; the op must not see this.
        bus.mantissa   = $urandom;
        bus.zero_count = 6'($urandom);
    endtask

    task automatic await_done(input string tag, input int exp_lat, input bit chk_lz);
        int   cyc = 0;
        exp_t e;
        while (bus.done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        if (bus.done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, 64'(bus.result), 64'(e.res));
            check({tag, "_err"}, 64'(bus.count_err), 64'(e.err));
            check({tag, "_busy"}, 64'(bus.busy), 64'(0));
            if (chk_lz) check({tag, "_lz"}, 64'(lzc(bus.result)), 64'(e.zc));
        end else begin
            check({tag, "_done_seen"}, 64'(bus.done), 64'(1));
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        int          n_done;
        logic [31:0] held;
        logic [31:0] m;
        logic [5:0]  z;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.mantissa   = '0;
        bus.zero_count = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy",   64'(bus.busy),      64'(0));
        check("rst_done",   64'(bus.done),      64'(0));
        check("rst_result", 64'(bus.result),    64'(0));
        check("rst_err",    64'(bus.count_err), 64'(0));

        // Basic shifts and boundary counts
        issue(32'h8000_0000, 6'd0);
        await_done("zc0", 6, 1'b1);
        issue(32'hF000_0001, 6'd5);
        await_done("zc5", 6, 1'b0);
        held = 32'h0780_0000;
        tick();
        check("hold_result", 64'(bus.result), 64'(held));
        check("hold_done",   64'(bus.done),   64'(0));
        issue(32'h8000_0000, 6'd31);
        await_done("zc31", 6, 1'b1);
        issue(32'hFFFF_FFFF, 6'd32);
        await_done("zc32", 6, 1'b1);
        issue(32'hFFFF_FFFF, 6'd40);
        await_done("zc40", 6, 1'b0);
        issue(32'h0000_F000, 6'd4);
        await_done("unnorm", 6, 1'b0);

        // Start while busy is ignored
        issue(32'hC000_0000, 6'd3);
        tick();
        bus.start      = 1'b1;
        bus.mantissa   = 32'hFFFF_FFFF;
        bus.zero_count = 6'd1;
        tick();
        bus.start = 1'b0;
        await_done("ignore", 4, 1'b1);
        n_done = 0;
        repeat (8) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        check("ignore_extra_done", 64'(n_done), 64'(0));
        check("ignore_sb_empty",   64'(sb.size()), 64'(0));

        // Start accepted in the done cycle
        issue(32'h9000_0000, 6'd2);
        await_done("b2b_a", 6, 1'b1);
        issue(32'hA5A5_A5A5, 6'd8);
        await_done("b2b_b", 6, 1'b0);

        // Reset mid-op aborts with no completion
        bus.start      = 1'b1;
        bus.mantissa   = 32'h8000_0000;
        bus.zero_count = 6'd7;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",   64'(bus.busy),      64'(0));
        check("abort_result", 64'(bus.result),    64'(0));
        check("abort_err",    64'(bus.count_err), 64'(0));
        n_done = 0;
        repeat (10) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'(0));

        // Reset and start together: start dropped
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.mantissa   = 32'h8000_0000;
        bus.zero_count = 6'd1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", 64'(bus.busy), 64'(0));
        n_done = 0;
        repeat (8) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        check("rst_start_no_done", 64'(n_done), 64'(0));

        // Random regression with normalized mantissas
        for (int i = 0; i < 1500; i++) begin
            m = $urandom | 32'h8000_0000;
            z = 6'($urandom_range(0, 32));
            issue(m, z);
            await_done("rand", 6, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
